// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for a DIGITS-wide common-anode 7-segment bank.
//   It shows hex glyphs, supports per-digit blanking and leading-zero
//   suppression, double-buffers each frame so the display never tears, and
//   keeps all anodes off for a short dead time at the start of each slot to
//   avoid ghosting.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         capture value/blank_mask into the pending buffer
//   value        4*DIGITS nibbles, nibble i = digit i (digit 0 = rightmost)
//   blank_mask   bit i = 1 forces digit i dark
//   hex_en       1: nibbles 10-15 show A,b,C,d,E,F; 0: they show dark
//   lz_suppress  1: leading zero digits are dark (digit 0 is never suppressed)
//   Display      segments {a,b,c,d,e,f,g}, active-low, registered
//   Anode        one-hot digit enable, polarity set by ANODE_LOW, registered
//   frame_done   high for the single cycle in which the frame wraps
module seven_seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int ANODE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  hex_en,
    input  logic                  lz_suppress,
    output logic [6:0]            Display,
    output logic [DIGITS-1:0]     Anode,
    output logic                  frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF =
        (ANODE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0] BLACK = 7'h7F;

    // Active-low segment patterns for all sixteen nibble values.
    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]         presc_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   pend_value_reg;
    logic [DIGITS-1:0]     pend_blank_reg;
    logic                  pend_valid_reg;
    logic [4*DIGITS-1:0]   act_value_reg;
    logic [DIGITS-1:0]     act_blank_reg;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  in_dead;
    logic [DIGITS-1:0]     onehot;
    logic [DIGITS-1:0]     anode_next;
    logic [6:0]            glyph [DIGITS];

    assign slot_end   = (presc_reg == PRESC_LAST);
    assign frame_wrap = slot_end && (idx_reg == IDX_LAST);
    assign frame_done = frame_wrap;

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (presc_reg < PW'(DEAD_CYCLES));
        end
    endgenerate

    // Per-digit glyph from the active buffer; hex_en and lz_suppress act live.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       upper_zero;   // this nibble and every higher one are 0
            logic       lz_dark;
            logic       dark;

            assign nib        = act_value_reg[4*gi +: 4];
            assign upper_zero = (act_value_reg[4*DIGITS-1 : 4*gi] == '0);

            if (gi == 0) begin : g_lsd
                assign lz_dark = 1'b0;
            end else begin : g_upper
                assign lz_dark = lz_suppress && upper_zero;
            end

            assign dark = act_blank_reg[gi] || ((nib > 4'd9) && !hex_en) || lz_dark;
            assign glyph[gi] = dark ? BLACK : seg_lut(nib);
        end
    endgenerate

    assign onehot     = DIGITS'(1) << idx_reg;
    assign anode_next = in_dead ? ANODE_OFF
                      : ((ANODE_LOW != 0) ? ~onehot : onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg      <= '0;
            idx_reg        <= '0;
            pend_value_reg <= '0;
            pend_blank_reg <= '0;
            pend_valid_reg <= 1'b0;
            act_value_reg  <= '0;
            act_blank_reg  <= '0;
            Display        <= BLACK;
            Anode          <= ANODE_OFF;
        end else begin
            if (slot_end) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            // A load landing in the wrap cycle is held back: the older
            // pending contents commit now and the new ones wait a frame.
            if (frame_wrap && pend_valid_reg) begin
                act_value_reg <= pend_value_reg;
                act_blank_reg <= pend_blank_reg;
            end

            if (load) begin
                pend_value_reg <= value;
                pend_blank_reg <= blank_mask;
                pend_valid_reg <= 1'b1;
            end else if (frame_wrap) begin
                pend_valid_reg <= 1'b0;
            end

            Display <= glyph[idx_reg];
            Anode   <= anode_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int CDIV   = 8;
    localparam int DEAD   = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic        hex_en = 1'b1;
    logic        lz_suppress = 1'b0;
    logic [6:0]  Display;
    logic [3:0]  Anode;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model of the two buffers and the scoreboard of slot glyphs.
    logic [15:0] m_act_v, m_pend_v;
    logic [3:0]  m_act_b, m_pend_b;
    bit          m_pv;
    logic [6:0]  exp_q [$];

    seven_seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CDIV), .DEAD_CYCLES(DEAD), .ANODE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .blank_mask(blank_mask), .hex_en(hex_en), .lz_suppress(lz_suppress),
        .Display(Display), .Anode(Anode), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_glyph(input logic [15:0] v, input logic [3:0] b,
                                             input int i, input logic hx, input logic lz);
        logic [3:0] n;
        n = v[4*i +: 4];
        if (b[i]) return 7'h7F;
        if (n > 4'd9 && !hx) return 7'h7F;
        if (lz && i != 0 && (v >> (4*i)) == 16'h0) return 7'h7F;
        return GLYPH[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_display"}, 32'(Display), 32'h7F);
        chk({tag, "_anode"}, 32'(Anode), 32'hF);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    // Called at a sample point after reset release (state 0); counts edges
    // until the wrap cycle, which must be the 31st state.
    task automatic wait_wrap(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            load = 1'b0;
            n++;
        end
        chk(tag, 32'(n), 32'd31);
    endtask

    // Entered in the wrap cycle; runs one frame and leaves in the next wrap cycle.
    task automatic run_frame(input int mid_edge, input logic [15:0] mid_v, input logic [3:0] mid_b,
                             input bit end_load, input logic [15:0] end_v, input logic [3:0] end_b);
        logic [6:0] g;
        logic [3:0] an_exp;
        int s, k;
        g = 7'h7F;
        if (m_pv) begin
            m_act_v = m_pend_v; m_act_b = m_pend_b; m_pv = 1'b0;
        end
        if (load) begin
            m_pend_v = value; m_pend_b = blank_mask; m_pv = 1'b1;
        end
        for (int i = 0; i < DIGITS; i++)
            exp_q.push_back(ref_glyph(m_act_v, m_act_b, i, hex_en, lz_suppress));
        $display("frame: active=%h mask=%b hex_en=%0d lz=%0d expect %h %h %h %h",
                 m_act_v, m_act_b, hex_en, lz_suppress, exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
        @(posedge clk); #1;
        load = 1'b0;
        for (int e = 2; e <= 32; e++) begin
            @(posedge clk); #1;
            s = (e - 2) / CDIV;
            k = (e - 2) % CDIV;
            if (k == 0) g = exp_q.pop_front();
            an_exp = (k < DEAD) ? 4'hF : ~(4'b0001 << s);
            chk($sformatf("display_s%0d_k%0d", s, k), 32'(Display), 32'(g));
            chk($sformatf("anode_s%0d_k%0d", s, k), 32'(Anode), 32'(an_exp));
            chk($sformatf("frame_done_e%0d", e), 32'(frame_done), (e == 32) ? 32'd1 : 32'd0);
            if (e == mid_edge) begin
                load = 1'b1; value = mid_v; blank_mask = mid_b;
                m_pend_v = mid_v; m_pend_b = mid_b; m_pv = 1'b1;
            end else if (e == mid_edge + 1) begin
                load = 1'b0;
            end
            if (e == 32 && end_load) begin
                load = 1'b1; value = end_v; blank_mask = end_b;
            end
        end
    endtask

    initial begin
        m_act_v = '0; m_act_b = '0; m_pend_v = '0; m_pend_b = '0; m_pv = 1'b0;

        // Reset state, then load 1234 in the first cycle after release.
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b1; value = 16'h1234; blank_mask = 4'b0000;
        m_pend_v = 16'h1234; m_pend_b = 4'b0000; m_pv = 1'b1;
        wait_wrap("first_wrap");

        // 1234 shown; 00A5 loaded mid-frame must not disturb it.
        run_frame(10, 16'h00A5, 4'b0000, 1'b0, 16'h0, 4'h0);
        lz_suppress = 1'b1;
        run_frame(0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
        hex_en = 1'b0;
        run_frame(5, 16'h0000, 4'b0000, 1'b0, 16'h0, 4'h0);
        hex_en = 1'b1;
        // 0000 shown; 1111 loaded mid-frame, 2222 loaded in the wrap cycle.
        run_frame(20, 16'h1111, 4'b0000, 1'b1, 16'h2222, 4'b0000);
        run_frame(0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
        run_frame(12, 16'h8888, 4'b0101, 1'b0, 16'h0, 4'h0);
        lz_suppress = 1'b0;
        run_frame(0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);

        // Reset in the middle of slot 2.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset_outputs($sformatf("reset_hold%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_act_v = '0; m_act_b = '0; m_pend_v = '0; m_pend_b = '0; m_pv = 1'b0;
        #1;
        chk_reset_outputs("after_release");
        wait_wrap("wrap_after_reset");
        run_frame(0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
